gpio_ctrl: RTL and testbench

Parametrised GPIO register block for the RISC-V microcontroller. It is the next generation of the fixed 16-pin GPIO register file and sits on the same word-addressed peripheral bus. Pin count is a parameter. New over the previous generation: a two-flop input synchroniser, per-pin edge or level interrupt detection with polarity select, a sticky write-1-to-clear interrupt status register, atomic set/clear/toggle of the output data, and a registered interrupt request output.

---
 rtl/gpio_pkg.sv | 28 ++
 rtl/gpio_irq_detect.sv | 56 +++++
 rtl/gpio_ctrl.sv | 128 ++++++++++++
 tb/tb_gpio_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO register block: register addresses, ID defaults, reset values.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package gpio_pkg;

   // Word addresses of the register map (addr[5:2])
   localparam logic [3:0] ADDR_NAME       = 4'd0;
   localparam logic [3:0] ADDR_VERSION    = 4'd1;
   localparam logic [3:0] ADDR_TRISTATE   = 4'd2;
   localparam logic [3:0] ADDR_PINSTATE   = 4'd3;
   localparam logic [3:0] ADDR_IRQ_MASK   = 4'd4;
   localparam logic [3:0] ADDR_DATA       = 4'd5;
   localparam logic [3:0] ADDR_SCRATCH    = 4'd6;
   localparam logic [3:0] ADDR_IRQ_STATUS = 4'd7;
   localparam logic [3:0] ADDR_IRQ_EDGE   = 4'd8;
   localparam logic [3:0] ADDR_IRQ_POL    = 4'd9;
   localparam logic [3:0] ADDR_DATA_SET   = 4'd10;
   localparam logic [3:0] ADDR_DATA_CLR   = 4'd11;
   localparam logic [3:0] ADDR_DATA_TGL   = 4'd12;

   // Identification defaults
   localparam logic [31:0] DEF_CHIP_NAME    = 32'h48524a44;
   localparam logic [31:0] DEF_CHIP_VERSION = 32'h00000002;

   // Every pad comes out of reset as an input
   localparam logic [31:0] TRISTATE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/gpio_irq_detect.sv
// Pad synchroniser plus per-pin edge/level event detection into a sticky W1C status vector.
// Latency: pad change before edge N -> sync after N+1 -> status after N+2.
// Backpressure: none; events are captured every cycle, a same-cycle event beats a clear.
module gpio_irq_detect #(
   parameter int NPINS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NPINS-1:0] pins,
   input  logic [NPINS-1:0] edge_sel,
   input  logic [NPINS-1:0] pol,
   input  logic [NPINS-1:0] clr,
   output logic [NPINS-1:0] sync,
   output logic [NPINS-1:0] status
);

   logic [NPINS-1:0] s1;
   logic [NPINS-1:0] s2;
   logic [NPINS-1:0] prev;
   logic [NPINS-1:0] event_hit;

   // Two-flop synchroniser plus one delayed copy for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         s1   <= '0;
         s2   <= '0;
         prev <= '0;
      end else begin
         s1   <= pins;
         s2   <= s1;
         prev <= s2;
      end
   end

   // Per-pin event: edge or level, polarity chosen by pol
   always_comb begin
      event_hit = '0;
      for (int i = 0; i < NPINS; i++) begin
         if (edge_sel[i])
            event_hit[i] = pol[i] ? (s2[i] & ~prev[i]) : (~s2[i] & prev[i]);
         else
            event_hit[i] = pol[i] ? s2[i] : ~s2[i];
      end
   end

   // Sticky status; set has priority over a simultaneous clear
   always_ff @(posedge clk) begin
      if (reset)
         status <= '0;
      else
         status <= (status & ~clr) | event_hit;
   end

   assign sync = s2;

endmodule

// File: rtl/gpio_ctrl.sv
// Parametrised GPIO register file: pad direction/data, pin readback, interrupt config and status.
// Latency: reads return one cycle after sel is sampled; writes take effect at the sampling edge.
// Backpressure: none; the bus is always accepted, rdata holds when no read occurs.
module gpio_ctrl
   import gpio_pkg::*;
#(
   parameter int          NPINS        = 16,
   parameter logic [31:0] CHIP_NAME    = DEF_CHIP_NAME,
   parameter logic [31:0] CHIP_VERSION = DEF_CHIP_VERSION
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sel,
   input  logic [5:2]       addr,
   input  logic             r_wn,
   input  logic [3:0]       wben,
   input  logic [31:0]      wdata,
   input  logic [NPINS-1:0] ro_gpio_pinstate,
   output logic [31:0]      rdata,
   output logic [NPINS-1:0] rf_gpio_datareg,
   output logic [NPINS-1:0] rf_gpio_tristate,
   output logic             irq
);

   logic             wr_en;
   logic             rd_en;
   logic [31:0]      bmask;
   logic [NPINS-1:0] pmask;
   logic [NPINS-1:0] pdata;

   logic [NPINS-1:0] data_q;
   logic [NPINS-1:0] tristate_q;
   logic [NPINS-1:0] mask_q;
   logic [NPINS-1:0] edge_q;
   logic [NPINS-1:0] pol_q;
   logic [31:0]      scratch_q;

   logic [NPINS-1:0] status;
   logic [NPINS-1:0] sync;
   logic [NPINS-1:0] status_clr;
   logic [31:0]      rd_mux;

   assign wr_en = sel & ~r_wn;
   assign rd_en = sel & r_wn;

   // Byte enables gate every write, including the strobe-style registers
   assign bmask = {{8{wben[3]}}, {8{wben[2]}}, {8{wben[1]}}, {8{wben[0]}}};
   assign pmask = bmask[NPINS-1:0];
   assign pdata = wdata[NPINS-1:0] & pmask;

   assign status_clr = (wr_en && addr == ADDR_IRQ_STATUS) ? pdata : '0;

   gpio_irq_detect #(
      .NPINS (NPINS)
   ) u_irq_detect (
      .clk      (clk),
      .reset    (reset),
      .pins     (ro_gpio_pinstate),
      .edge_sel (edge_q),
      .pol      (pol_q),
      .clr      (status_clr),
      .sync     (sync),
      .status   (status)
   );

   // Register writes; reset wins over any access in the same cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q     <= '0;
         tristate_q <= TRISTATE_RST[NPINS-1:0];
         mask_q     <= '0;
         edge_q     <= '0;
         pol_q      <= '0;
         scratch_q  <= '0;
      end else if (wr_en) begin
         case (addr)
            ADDR_TRISTATE: tristate_q <= (tristate_q & ~pmask) | pdata;
            ADDR_IRQ_MASK: mask_q     <= (mask_q & ~pmask) | pdata;
            ADDR_DATA:     data_q     <= (data_q & ~pmask) | pdata;
            ADDR_SCRATCH:  scratch_q  <= (scratch_q & ~bmask) | (wdata & bmask);
            ADDR_IRQ_EDGE: edge_q     <= (edge_q & ~pmask) | pdata;
            ADDR_IRQ_POL:  pol_q      <= (pol_q & ~pmask) | pdata;
            ADDR_DATA_SET: data_q     <= data_q | pdata;
            ADDR_DATA_CLR: data_q     <= data_q & ~pdata;
            ADDR_DATA_TGL: data_q     <= data_q ^ pdata;
            default: ;
         endcase
      end
   end

   // Read mux; pin registers zero-extend, write-only and reserved slots read 0
   always_comb begin
      rd_mux = '0;
      case (addr)
         ADDR_NAME:       rd_mux = CHIP_NAME;
         ADDR_VERSION:    rd_mux = CHIP_VERSION;
         ADDR_TRISTATE:   rd_mux = 32'(tristate_q);
         ADDR_PINSTATE:   rd_mux = 32'(sync);
         ADDR_IRQ_MASK:   rd_mux = 32'(mask_q);
         ADDR_DATA:       rd_mux = 32'(data_q);
         ADDR_SCRATCH:    rd_mux = scratch_q;
         ADDR_IRQ_STATUS: rd_mux = 32'(status);
         ADDR_IRQ_EDGE:   rd_mux = 32'(edge_q);
         ADDR_IRQ_POL:    rd_mux = 32'(pol_q);
         default:         rd_mux = '0;
      endcase
   end

   // Registered read data, held between reads
   always_ff @(posedge clk) begin
      if (reset)
         rdata <= '0;
      else if (rd_en)
         rdata <= rd_mux;
   end

   // Registered interrupt request from enabled pending bits
   always_ff @(posedge clk) begin
      if (reset)
         irq <= 1'b0;
      else
         irq <= |(status & mask_q);
   end

   assign rf_gpio_datareg  = data_q;
   assign rf_gpio_tristate = tristate_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: 16-pin instance for the main sequence, 8-pin instance for width clipping.
// Latency: bus tasks drive on negedge and return on the following negedge.
// Backpressure: n/a.
module tb_gpio_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        sel;
   logic [5:2]  addr;
   logic        r_wn;
   logic [3:0]  wben;
   logic [31:0] wdata;
   logic [15:0] pins;
   logic [31:0] rdata;
   logic [15:0] datareg;
   logic [15:0] tristate;
   logic        irq;
   logic [31:0] rdata8;
   logic [7:0]  datareg8;
   logic [7:0]  tristate8;
   logic        irq8;
   logic [31:0] rd;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   gpio_ctrl #(.NPINS(16)) u_dut (
      .clk              (clk),
      .reset            (reset),
      .sel              (sel),
      .addr             (addr),
      .r_wn             (r_wn),
      .wben             (wben),
      .wdata            (wdata),
      .ro_gpio_pinstate (pins),
      .rdata            (rdata),
      .rf_gpio_datareg  (datareg),
      .rf_gpio_tristate (tristate),
      .irq              (irq)
   );

   gpio_ctrl #(.NPINS(8)) u_dut8 (
      .clk              (clk),
      .reset            (reset),
      .sel              (sel),
      .addr             (addr),
      .r_wn             (r_wn),
      .wben             (wben),
      .wdata            (wdata),
      .ro_gpio_pinstate (pins[7:0]),
      .rdata            (rdata8),
      .rf_gpio_datareg  (datareg8),
      .rf_gpio_tristate (tristate8),
      .irq              (irq8)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      sel = 1'b1; r_wn = 1'b0; addr = a; wdata = d; wben = be;
      @(negedge clk);
      sel = 1'b0; wben = 4'h0;
   endtask

   task automatic rdreg(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      sel = 1'b1; r_wn = 1'b1; addr = a;
      @(negedge clk);
      sel = 1'b0;
      d = rdata;
   endtask

   initial begin
      reset = 1'b1; sel = 1'b0; addr = 4'd0; r_wn = 1'b1; wben = 4'h0; wdata = '0; pins = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Reset state
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_data", 32'(datareg), 32'd0);
      check("rst_tristate", 32'(tristate), 32'h0000FFFF);
      rdreg(4'd0, rd); check("rd_name", rd, 32'h48524a44);
      rdreg(4'd1, rd); check("rd_version", rd, 32'h00000002);
      rdreg(4'd2, rd); check("rd_tristate", rd, 32'h0000FFFF);

      // Byte-enabled write: only byte 0 lands
      wr(4'd5, 32'hA5A5A5A5, 4'b0001);
      check("be_data", 32'(datareg), 32'h000000A5);
      rdreg(4'd5, rd); check("be_rd_data", rd, 32'h000000A5);

      // Atomic ops: F0 |3 = F3, &~10 = E3, ^FF00 = FFE3
      wr(4'd5, 32'h000000F0, 4'hF);
      wr(4'd10, 32'h00000003, 4'hF);
      wr(4'd11, 32'h00000010, 4'hF);
      wr(4'd12, 32'h0000FF00, 4'hF);
      check("atomic_data", 32'(datareg), 32'h0000FFE3);
      rdreg(4'd10, rd); check("rd_set_zero", rd, 32'd0);
      rdreg(4'd11, rd); check("rd_clr_zero", rd, 32'd0);
      rdreg(4'd12, rd); check("rd_tgl_zero", rd, 32'd0);
      // Clear with only byte 0 enabled: FFE3 -> FF00
      wr(4'd11, 32'hFFFFFFFF, 4'b0001);
      check("clr_be_data", 32'(datareg), 32'h0000FF00);

      // Rising-edge interrupt on pin 4; other pins held high so level-low is idle
      pins = 16'hFFEF;
      repeat (4) @(negedge clk);
      wr(4'd8, 32'h00000010, 4'hF);
      wr(4'd9, 32'h00000010, 4'hF);
      wr(4'd7, 32'h0000FFFF, 4'hF);
      rdreg(4'd7, rd); check("status_cleared", rd, 32'd0);
      rdreg(4'd3, rd); check("pinstate", rd, 32'h0000FFEF);
      wr(4'd4, 32'h00000010, 4'hF);
      check("irq_idle", 32'(irq), 32'd0);
      @(negedge clk);
      pins = 16'hFFFF;
      @(posedge clk); #1;      // edge N
      check("irq_n", 32'(irq), 32'd0);
      @(posedge clk); #1;      // N+1
      check("irq_n1", 32'(irq), 32'd0);
      @(posedge clk); #1;      // N+2: status set
      check("irq_n2", 32'(irq), 32'd0);
      @(posedge clk); #1;      // N+3: irq up
      check("irq_n3", 32'(irq), 32'd1);
      rdreg(4'd7, rd); check("edge_status", rd, 32'h00000010);
      // Clear with wrong byte enabled has no effect
      wr(4'd7, 32'h00000010, 4'b0010);
      @(negedge clk);
      check("w1c_be_irq", 32'(irq), 32'd1);
      wr(4'd7, 32'h00000010, 4'hF);
      check("w1c_irq_lag", 32'(irq), 32'd1);
      @(negedge clk);
      check("w1c_irq_low", 32'(irq), 32'd0);

      // Level-low interrupt on pin 0
      wr(4'd4, 32'h00000001, 4'hF);
      pins = 16'hFFFE;
      repeat (4) @(negedge clk);
      rdreg(4'd7, rd); check("level_status", rd, 32'h00000001);
      check("level_irq", 32'(irq), 32'd1);
      wr(4'd7, 32'h00000001, 4'hF);
      rdreg(4'd7, rd); check("level_sticky", rd, 32'h00000001);
      pins = 16'hFFFF;
      repeat (3) @(negedge clk);
      wr(4'd7, 32'h00000001, 4'hF);
      rdreg(4'd7, rd); check("level_cleared", rd, 32'd0);
      check("level_irq_low", 32'(irq), 32'd0);

      // Scratch full width, then reset during a TRISTATE write
      wr(4'd6, 32'h12345678, 4'hF);
      rdreg(4'd6, rd); check("scratch", rd, 32'h12345678);
      @(negedge clk);
      sel = 1'b1; r_wn = 1'b0; addr = 4'd2; wdata = 32'd0; wben = 4'hF; reset = 1'b1;
      @(negedge clk);
      sel = 1'b0; reset = 1'b0;
      check("rst_abort_tristate", 32'(tristate), 32'h0000FFFF);
      rdreg(4'd6, rd); check("rst_scratch", rd, 32'd0);

      // 8-pin instance: upper bits clipped; reserved slot reads 0
      wr(4'd5, 32'hFFFFFFFF, 4'hF);
      rdreg(4'd5, rd);
      check("n8_data", rdata8, 32'h000000FF);
      check("n16_data", rd, 32'h0000FFFF);
      rdreg(4'd14, rd);
      check("n8_reserved", rdata8, 32'd0);
      check("n16_reserved", rd, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
